// File: rtl/imem_pkg.sv
// Shared constants for the instruction memory and the decode stage.
// Opcode field layout and the NOOP encoding live here.
package imem_pkg;

  localparam int OPC_W  = 6;
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;

  localparam logic [OPC_W-1:0] OPC_JMP       = 6'b000001;
  localparam logic [3:0]       OPC_BR_PREFIX = 4'b1000;
  localparam logic [31:0]      NOOP          = 32'h0;

  function automatic logic is_branch(input logic [OPC_W-1:0] opc);
    return opc[OPC_W-1 -: 4] == OPC_BR_PREFIX;
  endfunction

  function automatic logic is_jump(input logic [OPC_W-1:0] opc);
    return opc == OPC_JMP;
  endfunction

endpackage

// File: rtl/imem_predecode.sv
// Combinational branch/jump predecode of an instruction's opcode field.
// Shared by the fetch output register and the decode stage.
module imem_predecode
  import imem_pkg::*;
(
  input  logic [OPC_W-1:0] opc,
  output logic             branch,
  output logic             jump
);

  always_comb begin
    branch = is_branch(opc);
    jump   = is_jump(opc);
  end

endmodule

// File: rtl/imem_sync.sv
// RAM-backed instruction memory with a registered, stallable fetch port,
// per-word valid bitmap, out-of-range detection and registered predecode.
module imem_sync
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              clear_all,
  input  logic              fetch_req,
  input  logic [PC_W-1:0]   pc,
  input  logic              stall,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instruction,
  output logic              branch,
  output logic              jump,
  output logic              addr_fault
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  vbit;

  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic [DATA_W-1:0] sel_word;
  logic              pd_br;
  logic              pd_jmp;

  logic              nxt_valid;
  logic [DATA_W-1:0] nxt_instr;
  logic              nxt_br;
  logic              nxt_jmp;
  logic              nxt_fault;

  // Contents are never reset; the bitmap masks stale words.
  always_ff @(posedge clk) begin
    if (!rst && load_en)
      mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vbit <= '0;
    end else begin
      if (clear_all)
        vbit <= '0;
      if (load_en)
        vbit[load_addr] <= 1'b1;
    end
  end

  assign idx      = pc[ADDR_W-1:0];
  assign in_range = (pc >> ADDR_W) == '0;

  // Read-old: sampled before this edge's load/clear take effect.
  assign sel_word = vbit[idx] ? mem[idx] : DATA_W'(NOOP);

  imem_predecode u_pd (
    .opc    (sel_word[OPC_HI:OPC_LO]),
    .branch (pd_br),
    .jump   (pd_jmp)
  );

  always_comb begin
    nxt_valid = 1'b0;
    nxt_instr = '0;
    nxt_br    = 1'b0;
    nxt_jmp   = 1'b0;
    nxt_fault = 1'b0;
    if (fetch_req) begin
      nxt_valid = 1'b1;
      if (in_range) begin
        nxt_instr = sel_word;
        nxt_br    = pd_br;
        nxt_jmp   = pd_jmp;
      end else begin
        nxt_fault = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_valid <= 1'b0;
      instruction <= '0;
      branch      <= 1'b0;
      jump        <= 1'b0;
      addr_fault  <= 1'b0;
    end else if (!stall) begin
      instr_valid <= nxt_valid;
      instruction <= nxt_instr;
      branch      <= nxt_br;
      jump        <= nxt_jmp;
      addr_fault  <= nxt_fault;
    end
  end

endmodule

// File: tb/tb_imem_sync.sv
// Scoreboard bench for imem_sync: reference model predicts each
// registered fetch result, queued at drive time and popped after the edge.
module tb_imem_sync;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int PW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          clear_all;
  logic          fetch_req;
  logic [PW-1:0] pc;
  logic          stall;
  logic          instr_valid;
  logic [DW-1:0] instruction;
  logic          branch;
  logic          jump;
  logic          addr_fault;

  imem_sync #(.DATA_W(DW), .ADDR_W(AW), .PC_W(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .clear_all   (clear_all),
    .fetch_req   (fetch_req),
    .pc          (pc),
    .stall       (stall),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .branch      (branch),
    .jump        (jump),
    .addr_fault  (addr_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] i;
    logic          b;
    logic          j;
    logic          f;
  } exp_t;

  exp_t          sb[$];
  exp_t          held;
  logic [DW-1:0] ref_mem [DEPTH];
  logic          ref_v   [DEPTH];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    check({tag, ".valid"}, 64'(instr_valid), 64'(e.v));
    check({tag, ".instr"}, 64'(instruction), 64'(e.i));
    check({tag, ".br"},    64'(branch),      64'(e.b));
    check({tag, ".jmp"},   64'(jump),        64'(e.j));
    check({tag, ".fault"}, 64'(addr_fault),  64'(e.f));
  endtask

  function automatic exp_t predict(input logic fr, input logic [PW-1:0] p);
    exp_t          e;
    logic [DW-1:0] w;
    e = '0;
    if (fr) begin
      e.v = 1'b1;
      if (p >= DEPTH) begin
        e.f = 1'b1;
      end else begin
        w   = ref_v[p[AW-1:0]] ? ref_mem[p[AW-1:0]] : '0;
        e.i = w;
        e.b = (w[31:28] == 4'b1000);
        e.j = (w[31:26] == 6'b000001);
      end
    end
    return e;
  endfunction

  task automatic step(input string tag, input logic le,
                      input logic [AW-1:0] la, input logic [DW-1:0] ld,
                      input logic ca, input logic fr,
                      input logic [PW-1:0] p, input logic st);
    exp_t e;
    load_en   = le;
    load_addr = la;
    load_data = ld;
    clear_all = ca;
    fetch_req = fr;
    pc        = p;
    stall     = st;
    e = st ? held : predict(fr, p);
    if (ca)
      for (int k = 0; k < DEPTH; k++) ref_v[k] = 1'b0;
    if (le) begin
      ref_mem[la] = ld;
      ref_v[la]   = 1'b1;
    end
    held = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check_out(tag, e);
    end
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step("load", 1'b1, a, d, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic fetch(input string tag, input logic [PW-1:0] p);
    step(tag, 1'b0, '0, '0, 1'b0, 1'b1, p, 1'b0);
  endtask

  initial begin
    exp_t zero;
    zero = '0;
    held = '0;
    for (int k = 0; k < DEPTH; k++) ref_v[k] = 1'b0;
    rst = 1'b1;
    load_en = 0; load_addr = '0; load_data = '0; clear_all = 0;
    fetch_req = 0; pc = '0; stall = 0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", zero);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: async reset between edges
    load(8'd0, 32'hE4200000);
    fetch("pre_rst", 32'd0);
    check("pre_rst.word", 64'(instruction), 64'hE4200000);
    fetch_req = 1'b0;
    #2 rst = 1'b1;
    #1 check_out("async_rst", zero);
    for (int k = 0; k < DEPTH; k++) ref_v[k] = 1'b0;
    held = '0;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    fetch("post_rst", 32'd0);

    // 2: program load and fetch
    load(8'd10, 32'h8CA1000A);
    load(8'd21, 32'h0400FFEA);
    fetch("f10", 32'd10);
    check("f10.br_const", 64'(branch), 64'd1);
    fetch("f21", 32'd21);
    check("f21.jmp_const", 64'(jump), 64'd1);
    fetch("f5", 32'd5);

    // 3: stall holds outputs
    fetch("s10", 32'd10);
    for (int k = 0; k < 3; k++)
      step("stall", 1'b0, '0, '0, 1'b0, 1'b1, 32'd21, 1'b1);
    check("stall.word", 64'(instruction), 64'h8CA1000A);
    fetch("s21", 32'd21);

    // 4: out of range
    fetch("f256", 32'd256);
    check("f256.fault_const", 64'(addr_fault), 64'd1);
    fetch("f255", 32'd255);
    fetch("fbig", 32'h8000_0003);

    // 5: read/write collision
    load(8'd3, 32'h11111111);
    step("coll", 1'b1, 8'd3, 32'h22222222, 1'b0, 1'b1, 32'd3, 1'b0);
    check("coll.old", 64'(instruction), 64'h11111111);
    fetch("coll_new", 32'd3);
    check("coll.new", 64'(instruction), 64'h22222222);

    // 6: clear_all with concurrent load
    load(8'd1, 32'h0400_0001);
    load(8'd2, 32'h8000_0002);
    step("clr", 1'b1, 8'd2, 32'hE4200000, 1'b1, 1'b1, 32'd1, 1'b0);
    fetch("clr_f1", 32'd1);
    check("clr_f1.zero", 64'(instruction), 64'd0);
    fetch("clr_f2", 32'd2);
    check("clr_f2.word", 64'(instruction), 64'hE4200000);
    fetch("idle", 32'd2);
    step("nofetch", 1'b0, '0, '0, 1'b0, 1'b0, 32'd2, 1'b0);

    // Mixed random traffic
    for (int n = 0; n < 400; n++) begin
      logic [DW-1:0] d;
      d = $urandom;
      case ($urandom_range(0, 3))
        0: d[31:26] = 6'b000001;
        1: d[31:28] = 4'b1000;
        default: ;
      endcase
      step("rand",
           $urandom_range(0, 2) == 0,
           AW'($urandom_range(0, 31)),
           d,
           $urandom_range(0, 40) == 0,
           $urandom_range(0, 3) != 0,
           PW'($urandom_range(0, 40) == 0 ? $urandom_range(256, 600)
                                          : $urandom_range(0, 31)),
           $urandom_range(0, 4) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_sync.md
Name: imem_sync

Overview:
Synchronous, parametrised instruction memory for the basic CPU.
- Replaces the hard-coded combinational program ROM with a RAM-backed store that software or the bench loads at run time.
- Provides a one-cycle registered fetch with stall support, per-word valid tracking (unwritten words read as NOOP), out-of-range detection, and registered branch/jump predecode for the fetch/decode boundary.

Parameters:
DATA_W, 32, instruction width in bits
ADDR_W, 8, word-address bits; depth DEPTH = 2**ADDR_W words
PC_W, 32, width of the incoming program counter (word address)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
load_en  in  1  write one program word this cycle
load_addr  in  ADDR_W  word address of program write
load_data  in  DATA_W  program word
clear_all  in  1  invalidate every stored word (one cycle)
fetch_req  in  1  request fetch at pc
pc  in  PC_W  word address to fetch
stall  in  1  hold all fetch outputs
instr_valid  out  1  instruction/branch/jump/addr_fault are valid
instruction  out  DATA_W  fetched word (0 = NOOP)
branch  out  1  fetched opcode[5:2] == 4'b1000 (opcodes 100000..100011)
jump  out  1  fetched opcode == 6'b000001
addr_fault  out  1  fetched pc was >= DEPTH

Behaviour:
- Reset (async, rst=1): instr_valid, instruction, branch, jump and addr_fault go 0 immediately. The valid bitmap (DEPTH bits) clears. RAM contents are not reset; the bitmap masks them. Loads and fetches are ignored while rst=1.
- Load: when load_en=1, mem[load_addr] <= load_data and vbit[load_addr] <= 1 at the edge. Loads are accepted regardless of stall.
- clear_all=1: all vbit <= 0.
  - If load_en=1 in the same cycle, vbit[load_addr] <= 1 (load wins for that word) and the word is written.
- Fetch latency is 1 cycle. At an edge with stall=0:
  - fetch_req=1, pc < DEPTH:
    - instr_valid <= 1, addr_fault <= 0.
    - instruction <= vbit[pc] ? mem[pc] : 0.
  - fetch_req=1, pc >= DEPTH (any bit above ADDR_W-1 set):
    - instr_valid <= 1, addr_fault <= 1.
    - instruction <= 0, branch <= 0, jump <= 0.
  - fetch_req=0: instr_valid <= 0; instruction, branch, jump and addr_fault <= 0.
- stall=1: every fetch output register holds its value; fetch_req and pc are ignored that cycle. Back-to-back fetches under stall=0 give one result per cycle.
- Read/write collision (same cycle, fetch address == load_addr, in range): the fetch returns the pre-write content and pre-write vbit (read-old). The new word is visible from the next fetch.
- Fetch concurrent with clear_all returns the pre-clear content.
- Predecode is computed from the selected word (after NOOP masking) and registered with it, so it is always coherent with instruction. NOOP gives branch=0, jump=0.
- No internal FSM beyond the output register and bitmap. There are no handshake back-pressure outputs; the upstream PC logic owns stall.

Decomposition:
- Package imem_pkg:
  - OPC_W=6, OPC_JMP=6'b000001, OPC_BR_PREFIX=4'b1000, NOOP=32'h0.
  - Opcode field position [31:26] as constants.
- Sub-module imem_predecode (combinational: word -> branch, jump). The decode stage reuses it.
- RAM array, bitmap and output register stay in imem_sync.

Test Plan:
1. Reset mid-fetch: load addr 0 = 32'hE4200000, fetch pc=0, assert rst asynchronously between edges -> all outputs 0 at once, no wait for clk. After release, fetch pc=0 -> instruction=0 (bitmap cleared).
2. Load/fetch program: load addr 10 = 32'h8CA1000A and addr 21 = 32'h0400FFEA.
   - Fetch pc=10 -> next cycle instr_valid=1, instruction=32'h8CA1000A, branch=1, jump=0.
   - Fetch pc=21 -> instruction=32'h0400FFEA, jump=1, branch=0.
   - Fetch pc=5 (unwritten) -> instruction=0, branch=0, jump=0, instr_valid=1.
3. Stall: fetch pc=10, then stall=1 for 3 cycles while pc=21 and fetch_req=1 -> outputs hold 32'h8CA1000A / branch=1. Drop stall -> next cycle shows pc=21 word.
4. Out of range (ADDR_W=8): fetch pc=256 -> instr_valid=1, addr_fault=1, instruction=0. Fetch pc=255 next -> addr_fault=0.
5. Collision: addr 3 holds 32'h11111111. Same cycle load addr 3 = 32'h22222222 and fetch pc=3 -> 32'h11111111. Fetch pc=3 again -> 32'h22222222.
6. clear_all + load: addrs 1 and 2 loaded. Assert clear_all with load_en addr 2 = 32'hE4200000 -> fetch 1 returns 0, fetch 2 returns 32'hE4200000.
